rf_bank_req_queue: RTL and testbench

Per-bank register-file request queue between the operand-collector/RAU and one RF bank. It buffers up to two source-operand read requests per cycle and tags each with its destination operand-collector ID. It arbitrates the single bank port between queued reads and CDB writebacks. It is a parametrised successor of the existing bank request FIFO, adding:
- configurable depth and widths,
- a ready/backpressure handshake,
- a bounded-starvation write/read arbiter that can stall writeback.

---
 rtl/rf_req_pkg.sv | 28 ++
 rtl/rf_req_arbiter.sv | 50 +++++
 rtl/rf_bank_req_queue.sv | 147 ++++++++++++++
 tb/tb_rf_bank_req_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_req_pkg.sv
// Shared defaults and entry-layout helpers for the per-bank RF request queue.
// Entry layout, MSB to LSB: {same, ocid, row}.
// Offsets are functions so that parametrised widths keep one source of truth.
package rf_req_pkg;

  localparam int ROW_W_DEF  = 3;
  localparam int OCID_W_DEF = 3;
  localparam int DATA_W_DEF = 256;

  // Row field sits at the bottom of an entry.
  localparam int ROW_LSB = 0;

  // Total stored width of one queued read request.
  function automatic int entry_w(input int ocid_w, input int row_w);
    return 1 + ocid_w + row_w;
  endfunction

  // OC ID sits directly above the row field.
  function automatic int ocid_lsb(input int row_w);
    return row_w;
  endfunction

  // The same-row flag is the entry MSB.
  function automatic int same_bit(input int ocid_w, input int row_w);
    return ocid_w + row_w;
  endfunction

endpackage

// File: rtl/rf_req_arbiter.sv
// Bank-port arbiter: CDB writeback normally wins, queued reads get a forced slot.
// Latency: grant/issue are combinational; only the starvation counter is registered.
// Backpressure: wr_ready_o drops for one cycle once a read has waited STARVE_MAX write cycles.
module rf_req_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic empty_i,
  input  logic wr_valid_i,
  output logic wr_ready_o,
  output logic rf_wr_o,
  output logic rd_valid_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          starve_hit;

  assign starve_hit = (starve_q == SW'(STARVE_MAX));

  // Grant decision: a starved pending read steals the port from the writeback.
  always_comb begin
    wr_ready_o = !(starve_hit && !empty_i);
    rf_wr_o    = wr_valid_i && wr_ready_o;
    rd_valid_o = !empty_i && !rf_wr_o;
  end

  // Count consecutive write wins that pass over a pending read, saturating.
  always_comb begin
    starve_d = starve_q;
    if (rd_valid_o || empty_i) begin
      starve_d = '0;
    end else if (rf_wr_o && !starve_hit) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/rf_bank_req_queue.sv
// Per-bank RF read-request queue, tagging each read with its destination OC ID.
// Latency: an entry enqueued at edge N is issuable in cycle N+1; pop is combinational from the head.
// Backpressure: all-or-nothing in_ready against pre-pop free space; writebacks may be stalled.
module rf_bank_req_queue
  import rf_req_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ROW_W      = ROW_W_DEF,
  parameter int OCID_W     = OCID_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid0,
  input  logic                       in_valid1,
  input  logic [ROW_W-1:0]           in_row0,
  input  logic [ROW_W-1:0]           in_row1,
  input  logic [OCID_W-1:0]          in_ocid0,
  input  logic [OCID_W-1:0]          in_ocid1,
  input  logic                       in_same,
  output logic                       in_ready,
  input  logic                       wr_valid,
  input  logic [ROW_W-1:0]           wr_row,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic [ROW_W-1:0]           rf_addr,
  output logic                       rf_wr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       rd_valid,
  output logic [OCID_W-1:0]          rd_ocid,
  output logic                       rd_same,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW       = $clog2(DEPTH);
  localparam int PW       = AW + 1;
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int EW       = entry_w(OCID_W, ROW_W);
  localparam int OCID_LSB = ocid_lsb(ROW_W);
  localparam int SAME_BIT = same_bit(OCID_W, ROW_W);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] used;
  logic [PW-1:0] free_slots;
  logic [1:0]    need;
  logic          push;
  logic          same_push;
  logic [EW-1:0] ent0, ent1, head;
  logic [AW-1:0] wr_idx0, wr_idx1;

  assign used       = wr_ptr_q - rd_ptr_q;
  assign free_slots = PW'(DEPTH) - used;
  assign count      = CW'(used);
  assign empty      = (used == '0);
  assign full       = (used == PW'(DEPTH));
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_idx0    = wr_ptr_q[AW-1:0];
  assign wr_idx1    = wr_ptr_q[AW-1:0] + AW'(1);
  assign rf_wdata   = wr_data;

  // Work out how many entries this cycle wants and build them in enqueue order.
  always_comb begin
    same_push = in_same && in_valid0;
    need      = 2'd0;
    ent0      = '0;
    ent1      = {1'b0, in_ocid1, in_row1};
    if (same_push) begin
      need = 2'd1;
      ent0 = {1'b1, in_ocid0, in_row0};
    end else if (in_valid0) begin
      need = in_valid1 ? 2'd2 : 2'd1;
      ent0 = {1'b0, in_ocid0, in_row0};
    end else if (in_valid1) begin
      need = 2'd1;
      ent0 = {1'b0, in_ocid1, in_row1};
    end
    in_ready = (free_slots >= PW'(need));
    push     = in_ready && (need != 2'd0);
  end

  rf_req_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .empty_i    (empty),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .rf_wr_o    (rf_wr),
    .rd_valid_o (rd_valid)
  );

  // Bank port mux and issued-read fields; zero whenever nothing is issued.
  always_comb begin
    rf_addr = '0;
    rd_ocid = '0;
    rd_same = 1'b0;
    if (rf_wr) begin
      rf_addr = wr_row;
    end else if (rd_valid) begin
      rf_addr = head[ROW_LSB +: ROW_W];
    end
    if (rd_valid) begin
      rd_ocid = head[OCID_LSB +: OCID_W];
      rd_same = head[SAME_BIT];
    end
  end

  // Pointer next-state: push advances by need, pop by one.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(need);
    end
    if (rd_valid) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers; extra MSB separates full from empty across wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents need no reset since nothing is exposed while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx0] <= ent0;
      if (need == 2'd2) begin
        mem_q[wr_idx1] <= ent1;
      end
    end
  end

endmodule

// File: tb/tb_rf_bank_req_queue.sv
// Directed bench for rf_bank_req_queue: vector table plus hand-written corner sequences.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 4 units after it.
// Stream phase keeps a FIFO-order scoreboard across pointer wrap and a mid-stream reset.
module tb_rf_bank_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid0, in_valid1, in_same;
  logic [2:0]  in_row0, in_row1, in_ocid0, in_ocid1;
  logic        in_ready;
  logic        wr_valid;
  logic [2:0]  wr_row;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [2:0]  rf_addr;
  logic        rf_wr;
  logic [15:0] rf_wdata;
  logic        rd_valid;
  logic [2:0]  rd_ocid;
  logic        rd_same;
  logic [3:0]  count;
  logic        full, empty;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  rf_bank_req_queue #(
    .DEPTH(8), .ROW_W(3), .OCID_W(3), .DATA_W(16), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_row0(in_row0), .in_row1(in_row1),
    .in_ocid0(in_ocid0), .in_ocid1(in_ocid1),
    .in_same(in_same), .in_ready(in_ready),
    .wr_valid(wr_valid), .wr_row(wr_row), .wr_data(wr_data), .wr_ready(wr_ready),
    .rf_addr(rf_addr), .rf_wr(rf_wr), .rf_wdata(rf_wdata),
    .rd_valid(rd_valid), .rd_ocid(rd_ocid), .rd_same(rd_same),
    .count(count), .full(full), .empty(empty)
  );

  // in_same without in_valid0 is an illegal request pattern.
  always @(negedge clk) begin
    if (!rst) assert (!(in_same && !in_valid0)) else $error("in_same asserted without in_valid0");
  end

  typedef struct {
    logic       v0, v1, same;
    logic [2:0] r0, r1, o0, o1;
    logic       wv;
    logic [2:0] wrow;
    logic       e_rdy, e_rdv;
    logic [2:0] e_addr, e_ocid;
    logic       e_same, e_rfwr;
    int         e_cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_valid0 = 0; in_valid1 = 0; in_same = 0;
    in_row0 = 0; in_row1 = 0; in_ocid0 = 0; in_ocid1 = 0;
    wr_valid = 0; wr_row = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [2:0] r, input logic [2:0] o, input logic wv);
    idle();
    in_valid0 = 1; in_row0 = r; in_ocid0 = o;
    wr_valid = wv; wr_row = 3'd1;
  endtask

  task automatic push2(input logic wv);
    idle();
    in_valid0 = 1; in_valid1 = 1; in_row0 = 3'd2; in_row1 = 3'd3;
    in_ocid0 = 3'd4; in_ocid1 = 3'd5;
    wr_valid = wv; wr_row = 3'd1;
  endtask

  logic [5:0] q[$];
  logic [5:0] exp_tag;
  int  sent;
  bit  did_rst;
  bit  hold;
  int  budget;

  initial begin
    // Vectors: inputs | in_ready rd_valid rf_addr rd_ocid rd_same rf_wr count(before edge)
    tbl[0]  = '{1,1,0, 5,1,2,4, 0,0, 1,0,0,0,0,0,0};
    tbl[1]  = '{0,0,0, 0,0,0,0, 0,0, 1,1,5,2,0,0,2};
    tbl[2]  = '{0,0,0, 0,0,0,0, 0,0, 1,1,1,4,0,0,1};
    tbl[3]  = '{1,1,1, 3,7,6,1, 0,0, 1,0,0,0,0,0,0};
    tbl[4]  = '{0,0,0, 0,0,0,0, 0,0, 1,1,3,6,1,0,1};
    tbl[5]  = '{1,1,0, 2,6,1,3, 1,7, 1,0,7,0,0,1,0};
    tbl[6]  = '{1,0,0, 4,0,5,0, 1,7, 1,0,7,0,0,1,2};
    tbl[7]  = '{1,1,0, 0,5,7,0, 0,0, 1,1,2,1,0,0,3};
    tbl[8]  = '{0,0,0, 0,0,0,0, 0,0, 1,1,6,3,0,0,4};
    tbl[9]  = '{0,0,0, 0,0,0,0, 0,0, 1,1,4,5,0,0,3};
    tbl[10] = '{0,0,0, 0,0,0,0, 0,0, 1,1,0,7,0,0,2};
    tbl[11] = '{0,0,0, 0,0,0,0, 0,0, 1,1,5,0,0,0,1};
    tbl[12] = '{0,0,0, 0,0,0,0, 0,0, 1,0,0,0,0,0,0};

    // Reset state.
    idle();
    wr_data = 16'hA5C3;
    rst = 1;
    in_valid0 = 1; in_valid1 = 1;
    #3;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_in_ready_need2", in_ready, 1);
    chk("wdata_passthru", rf_wdata, 16'hA5C3);
    idle();
    step();
    rst = 0;
    step();

    // Table-driven basic push/pop, same-row and push-2/pop-1 vectors.
    for (int i = 0; i < 13; i++) begin
      in_valid0 = tbl[i].v0; in_valid1 = tbl[i].v1; in_same = tbl[i].same;
      in_row0 = tbl[i].r0; in_row1 = tbl[i].r1;
      in_ocid0 = tbl[i].o0; in_ocid1 = tbl[i].o1;
      wr_valid = tbl[i].wv; wr_row = tbl[i].wrow;
      #3;
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, tbl[i].e_rdv);
      chk($sformatf("v%0d_rf_addr", i), rf_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_rd_ocid", i), rd_ocid, tbl[i].e_ocid);
      chk($sformatf("v%0d_rd_same", i), rd_same, tbl[i].e_same);
      chk($sformatf("v%0d_rf_wr", i), rf_wr, tbl[i].e_rfwr);
      chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
      step();
    end

    // Starvation: one queued read, writeback held high.
    push1(3'd2, 3'd3, 0);
    step();
    idle();
    wr_valid = 1; wr_row = 3'd6;
    for (int c = 1; c <= 4; c++) begin
      #3;
      chk($sformatf("starve_c%0d_rf_wr", c), rf_wr, 1);
      chk($sformatf("starve_c%0d_rd_valid", c), rd_valid, 0);
      chk($sformatf("starve_c%0d_count", c), count, 1);
      step();
    end
    #3;
    chk("starve_c5_wr_ready", wr_ready, 0);
    chk("starve_c5_rd_valid", rd_valid, 1);
    chk("starve_c5_rf_addr", rf_addr, 2);
    chk("starve_c5_rd_ocid", rd_ocid, 3);
    step();
    #3;
    chk("starve_c6_rf_wr", rf_wr, 1);
    chk("starve_c6_rf_addr", rf_addr, 6);
    chk("starve_c6_empty", empty, 1);
    step();

    // Fill to 7 with reads blocked, then probe the all-or-nothing boundary.
    push2(1); step();
    push2(1); step();
    push2(1); step();
    push1(3'd7, 3'd7, 1);
    #3; chk("fill_c4_count", count, 6);
    step();
    push2(1);
    #3;
    chk("fill_c5_count", count, 7);
    chk("fill_c5_in_ready", in_ready, 0);
    chk("fill_c5_rf_wr", rf_wr, 1);
    step();
    idle(); wr_valid = 1; wr_row = 3'd1;
    #3;
    chk("fill_c6_count_held", count, 7);
    chk("fill_c6_wr_ready", wr_ready, 0);
    chk("fill_c6_rd_valid", rd_valid, 1);
    step();
    push1(3'd6, 3'd6, 1);
    #3; chk("fill_c7_count", count, 6);
    step();
    push1(3'd5, 3'd5, 1);
    #3;
    chk("fill_c8_count", count, 7);
    chk("fill_c8_in_ready", in_ready, 1);
    step();
    push1(3'd4, 3'd4, 0);
    in_valid0 = 1;
    #3;
    chk("fill_c9_count", count, 8);
    chk("fill_c9_full", full, 1);
    chk("fill_c9_in_ready", in_ready, 0);
    step();
    idle();
    budget = 0;
    while (!empty && budget < 20) begin
      step();
      budget++;
    end
    #3;
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);
    step();

    // Stream 20 single entries with random writebacks; reset after 12 accepted.
    sent = 0; did_rst = 0; hold = 0; budget = 0;
    q.delete();
    while ((sent < 20 || q.size() != 0) && budget < 400) begin
      budget++;
      if (sent == 12 && !did_rst) begin
        idle();
        rst = 1;
        #1;
        chk("midrst_empty", empty, 1);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_count", count, 0);
        q.delete();
        hold = 0;
        did_rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        continue;
      end
      in_valid0 = (sent < 20);
      in_valid1 = 0; in_same = 0;
      in_row0 = sent[2:0]; in_ocid0 = sent[5:3];
      if (!hold) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_row = 3'($urandom_range(0, 7));
      end
      #3;
      chk("stream_count", count, q.size());
      if (in_valid0) chk("stream_in_ready", in_ready, (8 - q.size()) >= 1);
      if (rd_valid) begin
        if (q.size() == 0) begin
          chk("stream_stale_pop", 1, 0);
        end else begin
          exp_tag = q.pop_front();
          chk("stream_order", {rd_ocid, rf_addr}, exp_tag);
        end
      end
      if (in_valid0 && in_ready) begin
        q.push_back(sent[5:0]);
        sent++;
      end
      hold = wr_valid && !wr_ready;
      step();
    end
    chk("stream_all_sent", sent, 20);
    chk("stream_drained", q.size(), 0);
    idle();
    #3;
    chk("stream_end_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
